cmos_frame_gate: RTL and testbench
==================================

Name: cmos_frame_gate

Overview:
Per-camera frame gate between the OV5640 capture driver and the two-camera merge stage, in the camera pixel-clock domain. Starts passing pixels only at a frame boundary and only when capture is enabled. Decimates frames (keep 1 of N). Checks line and frame geometry against the nominal size so bring-up can see torn or short frames before they reach the DDR3 frame buffer.

Parameters:
H_PIXEL, 640, expected valid pixels per line
V_PIXEL, 360, expected lines per frame
CNT_W, 13, width of pixel and line counters and of the geometry outputs
VS_POL, 1, active level of in_vsync (1 = high); frame start is the edge into the active level

Ports:
cmos_pclk  in  1  camera pixel clock; the only clock
sys_rst  in  1  asynchronous, active-high reset
capture_en  in  1  capture enable; sampled only at frame start
keep_div  in  4  pass 1 frame, then skip keep_div frames; sampled at frame start
err_clr  in  1  one-cycle pulse that clears the sticky error flags
in_vsync  in  1  frame sync from the capture driver
in_href  in  1  line valid
in_valid  in  1  pixel strobe (one per assembled 16-bit pixel)
in_data  in  16  RGB565 pixel
out_vsync  out  1  in_vsync delayed 1 cycle; never gated
out_href  out  1  in_href delayed 1 cycle, gated by PASS
out_valid  out  1  in_valid delayed 1 cycle, gated by PASS
out_data  out  16  registered pixel; 0 whenever out_valid = 0
frame_active  out  1  high while in PASS
frame_cnt  out  16  count of frames entered into PASS; wraps
line_len_err  out  1  sticky: a passed line had pixel count != H_PIXEL
line_cnt_err  out  1  sticky: a passed frame had line count != V_PIXEL
last_line_len  out  CNT_W  pixel count of the most recent completed line
last_frame_lines  out  CNT_W  line count of the most recent completed frame

Behaviour:
- Reset values: all outputs 0; state IDLE; skip_cnt, pix_cnt and line_cnt all 0.
- Frame-start event fs: a registered copy of in_vsync is kept. fs is one cycle when in_vsync == VS_POL and the registered copy != VS_POL.
- States and transitions:
  - IDLE: waits for fs. At fs, goes to PASS if capture_en = 1, else stays in IDLE.
  - PASS and SKIP: at fs, if capture_en = 0, go to IDLE.
  - PASS and SKIP: at fs with capture_en = 1 and skip_cnt == 0, go to PASS and load skip_cnt <= keep_div.
  - PASS and SKIP: at fs with capture_en = 1 and skip_cnt != 0, go to SKIP and decrement skip_cnt.
  - IDLE to PASS also loads skip_cnt <= keep_div.
- The state changes only at fs. Dropping capture_en mid-frame lets the current frame finish. A frame already in progress at reset release is never passed.
- Latency: exactly 1 cycle from in_* to out_*. Gating uses the state value that applies to that input cycle; the fs cycle itself already uses the new state.
- Pixel counting:
  - pix_cnt increments on in_valid && in_href and saturates at 2^CNT_W-1.
  - On an href falling edge (registered href = 1, in_href = 0): last_line_len <= pix_cnt, line_cnt += 1 (saturating), pix_cnt <= 0.
  - If the state is PASS and pix_cnt != H_PIXEL on that edge, set line_len_err.
- Frame closing at fs:
  - last_frame_lines <= line_cnt.
  - If the frame being closed was PASS and line_cnt != V_PIXEL, set line_cnt_err.
  - Clear line_cnt and pix_cnt. A partial line cut by fs is discarded and is not length-checked.
  - Entering PASS increments frame_cnt (wraps from 0xFFFF to 0).
- Error flags: err_clr clears both flags. If err_clr and a set condition occur in the same cycle, set wins.
- href rising and falling in the same cycle as fs: fs handling takes priority for the counters; the href edge is still tracked.

Decomposition:
- Shared package cmos_pkg:
  - state enum {IDLE, PASS, SKIP}
  - default H_PIXEL / V_PIXEL constants
  - RGB565 width constant (16)
- Sub-module cmos_geom_check holds the pix/line counters, saturation, the error flags and the last_* registers. The top level keeps edge detection, the FSM and output registering.

Test Plan:
- Reset release mid-frame, capture_en=1, 640x360 frames → first frame fully blocked (out_valid = 0). Second frame passes 230400 pixels; frame_cnt = 1; no errors.
- keep_div=2, 7 frames → frames 1, 4 and 7 pass; out_vsync toggles for all 7; frame_cnt = 3.
- capture_en dropped at line 100 of a passing frame → that frame completes all 360 lines; next frame is blocked; state goes to IDLE.
- One line of 639 pixels in a passed frame → line_len_err = 1, last_line_len = 639. err_clr pulsed later → flag cleared. err_clr in the same cycle as a new 641-pixel line end → flag stays 1.
- Frame with 359 lines → line_cnt_err = 1 at the next fs, last_frame_lines = 359. The same defect in a skipped frame → no error.
- Async sys_rst asserted mid-line with out_valid = 1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cmos_pkg.sv
// Shared types and constants for the per-camera frame gate.
// Nominal geometry defaults match the 640x360 capture mode of the OV5640 driver.
package cmos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    SKIP = 2'd2
  } gate_state_e;

  localparam int unsigned DEF_H_PIXEL = 640;
  localparam int unsigned DEF_V_PIXEL = 360;
  localparam int unsigned RGB565_W    = 16;

endpackage

// File: rtl/cmos_geom_check.sv
// Line/frame geometry checker: counts pixels and lines and flags passed
// lines or frames whose size differs from the nominal geometry.
module cmos_geom_check
  import cmos_pkg::*;
#(
  parameter int unsigned H_PIXEL = DEF_H_PIXEL,
  parameter int unsigned V_PIXEL = DEF_V_PIXEL,
  parameter int unsigned CNT_W   = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fs_i,
  input  logic             closing_pass_i,
  input  logic             href_i,
  input  logic             valid_i,
  input  logic             err_clr_i,
  output logic             line_len_err_o,
  output logic             line_cnt_err_o,
  output logic [CNT_W-1:0] last_line_len_o,
  output logic [CNT_W-1:0] last_frame_lines_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_PIXEL);
  localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_PIXEL);

  logic             href_q;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] llen_q, llen_d;
  logic [CNT_W-1:0] lframe_q, lframe_d;
  logic             len_err_q, len_err_d;
  logic             cnt_err_q, cnt_err_d;
  logic             len_set, cnt_set;

  // Frame start wins over a coincident line end, so a line cut by fs is dropped unchecked.
  always_comb begin
    pix_d    = pix_q;
    line_d   = line_q;
    llen_d   = llen_q;
    lframe_d = lframe_q;
    len_set  = 1'b0;
    cnt_set  = 1'b0;
    if (fs_i) begin
      lframe_d = line_q;
      cnt_set  = closing_pass_i && (line_q != V_EXP);
      pix_d    = '0;
      line_d   = '0;
    end else if (href_q && !href_i) begin
      llen_d  = pix_q;
      len_set = closing_pass_i && (pix_q != H_EXP);
      pix_d   = '0;
      line_d  = (line_q == CNT_MAX) ? line_q : line_q + 1'b1;
    end else if (valid_i && href_i && (pix_q != CNT_MAX)) begin
      pix_d = pix_q + 1'b1;
    end
    len_err_d = len_set | (len_err_q & ~err_clr_i);
    cnt_err_d = cnt_set | (cnt_err_q & ~err_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_q    <= 1'b0;
      pix_q     <= '0;
      line_q    <= '0;
      llen_q    <= '0;
      lframe_q  <= '0;
      len_err_q <= 1'b0;
      cnt_err_q <= 1'b0;
    end else begin
      href_q    <= href_i;
      pix_q     <= pix_d;
      line_q    <= line_d;
      llen_q    <= llen_d;
      lframe_q  <= lframe_d;
      len_err_q <= len_err_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign line_len_err_o     = len_err_q;
  assign line_cnt_err_o     = cnt_err_q;
  assign last_line_len_o    = llen_q;
  assign last_frame_lines_o = lframe_q;

endmodule

// File: rtl/cmos_frame_gate.sv
// Per-camera frame gate: starts passing only at a frame boundary, decimates
// frames (keep 1 of keep_div+1) and reports geometry errors for bring-up.
module cmos_frame_gate
  import cmos_pkg::*;
#(
  parameter int unsigned H_PIXEL = DEF_H_PIXEL,
  parameter int unsigned V_PIXEL = DEF_V_PIXEL,
  parameter int unsigned CNT_W   = 13,
  parameter logic        VS_POL  = 1'b1
) (
  input  logic                cmos_pclk,
  input  logic                sys_rst,
  input  logic                capture_en,
  input  logic [3:0]          keep_div,
  input  logic                err_clr,
  input  logic                in_vsync,
  input  logic                in_href,
  input  logic                in_valid,
  input  logic [RGB565_W-1:0] in_data,
  output logic                out_vsync,
  output logic                out_href,
  output logic                out_valid,
  output logic [RGB565_W-1:0] out_data,
  output logic                frame_active,
  output logic [15:0]         frame_cnt,
  output logic                line_len_err,
  output logic                line_cnt_err,
  output logic [CNT_W-1:0]    last_line_len,
  output logic [CNT_W-1:0]    last_frame_lines
);

  gate_state_e         state_q, state_d;
  logic [3:0]          skip_q, skip_d;
  logic                vsync_q;
  logic                fs;
  logic                pass_now;
  logic                enter_pass;
  logic                href_q, valid_q;
  logic [RGB565_W-1:0] data_q;
  logic [15:0]         fcnt_q;

  assign fs = (in_vsync == VS_POL) && (vsync_q != VS_POL);

  always_ff @(posedge cmos_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Decisions are taken only at frame start, so a frame is always passed or dropped whole.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (fs) begin
      case (state_q)
        IDLE: begin
          if (capture_en) begin
            state_d = PASS;
            skip_d  = keep_div;
          end
        end
        default: begin
          if (!capture_en) begin
            state_d = IDLE;
          end else if (skip_q == 4'd0) begin
            state_d = PASS;
            skip_d  = keep_div;
          end else begin
            state_d = SKIP;
            skip_d  = skip_q - 4'd1;
          end
        end
      endcase
    end
  end

  // Gating follows the state that owns the current input cycle, including the fs cycle.
  always_comb begin
    pass_now   = (state_d == PASS);
    enter_pass = fs && pass_now;
  end

  always_ff @(posedge cmos_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      vsync_q <= in_vsync;
      href_q  <= in_href && pass_now;
      valid_q <= in_valid && pass_now;
      data_q  <= (in_valid && pass_now) ? in_data : '0;
      if (enter_pass) begin
        fcnt_q <= fcnt_q + 16'd1;
      end
    end
  end

  assign out_vsync    = vsync_q;
  assign out_href     = href_q;
  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign frame_active = (state_q == PASS);
  assign frame_cnt    = fcnt_q;

  cmos_geom_check #(
    .H_PIXEL(H_PIXEL),
    .V_PIXEL(V_PIXEL),
    .CNT_W  (CNT_W)
  ) u_geom (
    .clk               (cmos_pclk),
    .rst               (sys_rst),
    .fs_i              (fs),
    .closing_pass_i    (state_q == PASS),
    .href_i            (in_href),
    .valid_i           (in_valid),
    .err_clr_i         (err_clr),
    .line_len_err_o    (line_len_err),
    .line_cnt_err_o    (line_cnt_err),
    .last_line_len_o   (last_line_len),
    .last_frame_lines_o(last_frame_lines)
  );

endmodule

// File: tb/tb_cmos_frame_gate.sv
// Self-checking bench for cmos_frame_gate on a reduced 16x8 geometry with a
// frame-level reference model of pass/skip decisions and a pixel scoreboard.
module tb_cmos_frame_gate;
  import cmos_pkg::*;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          capture_en, err_clr, in_vsync, in_href, in_valid;
  logic [3:0]    keep_div;
  logic [15:0]   in_data;
  logic          out_vsync, out_href, out_valid, frame_active;
  logic [15:0]   out_data, frame_cnt;
  logic          line_len_err, line_cnt_err;
  logic [CW-1:0] last_line_len, last_frame_lines;

  int checks   = 0;
  int failures = 0;

  logic [15:0] drvQ[$];
  logic [15:0] obsQ[$];
  int   dataLeak = 0;
  int   ovRise   = 0;
  logic prevOv   = 1'b0;

  bit mActive;
  int mSkip;
  int mFrameCnt;

  always #5 clk = ~clk;

  cmos_frame_gate #(
    .H_PIXEL(H),
    .V_PIXEL(V),
    .CNT_W  (CW),
    .VS_POL (1'b1)
  ) dut (
    .cmos_pclk       (clk),
    .sys_rst         (rst),
    .capture_en      (capture_en),
    .keep_div        (keep_div),
    .err_clr         (err_clr),
    .in_vsync        (in_vsync),
    .in_href         (in_href),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .out_vsync       (out_vsync),
    .out_href        (out_href),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .frame_active    (frame_active),
    .frame_cnt       (frame_cnt),
    .line_len_err    (line_len_err),
    .line_cnt_err    (line_cnt_err),
    .last_line_len   (last_line_len),
    .last_frame_lines(last_frame_lines)
  );

  // Output monitor: collects passed pixels and watches for data leaking past the gate.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) obsQ.push_back(out_data);
      else if (out_data !== 16'h0) dataLeak++;
      if (out_vsync && !prevOv) ovRise++;
      prevOv = out_vsync;
    end else begin
      prevOv = 1'b0;
    end
  end

  function automatic bit modelWillPass(input bit en, input int keep);
    if (!en) return 1'b0;
    return (!mActive || mSkip == 0);
  endfunction

  function automatic void modelStep(input bit en, input int keep);
    if (!en) begin
      mActive = 1'b0;
    end else if (!mActive || mSkip == 0) begin
      mActive   = 1'b1;
      mSkip     = keep;
      mFrameCnt = (mFrameCnt + 1) % 65536;
    end else begin
      mSkip = mSkip - 1;
    end
  endfunction

  function automatic void modelReset();
    mActive   = 1'b0;
    mSkip     = 0;
    mFrameCnt = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveLine(input int len, input bit pass, input bit clrAtEnd);
    int n = 0;
    in_href = 1'b1;
    while (n < len) begin
      in_data  = 16'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        if (pass) drvQ.push_back(in_data);
        n++;
      end
      tick();
    end
    in_valid = 1'b0;
    in_href  = 1'b0;
    in_data  = 16'($urandom);
    err_clr  = clrAtEnd;
    tick();
    err_clr = 1'b0;
    tick();
    tick();
  endtask

  task automatic driveFrame(input int nLines, input int oddLine, input int oddLen,
                            input int clrLine, input int dropLine,
                            output bit expPass, output int expPix, output int gotPix,
                            output bit dataOk);
    drvQ.delete();
    obsQ.delete();
    expPass = modelWillPass(capture_en, int'(keep_div));
    modelStep(capture_en, int'(keep_div));
    in_vsync = 1'b1;
    tick();
    tick();
    in_vsync = 1'b0;
    tick();
    tick();
    for (int l = 0; l < nLines; l++) begin
      if (l == dropLine) capture_en = 1'b0;
      driveLine((l == oddLine) ? oddLen : H, expPass, l == clrLine);
    end
    tick();
    tick();
    expPix = drvQ.size();
    gotPix = obsQ.size();
    dataOk = (expPix == gotPix);
    if (dataOk) begin
      for (int i = 0; i < expPix; i++) begin
        if (obsQ[i] !== drvQ[i]) dataOk = 1'b0;
      end
    end
  endtask

  task automatic pulseClear();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    capture_en = 1'b1; keep_div = 4'd0; err_clr = 1'b0;
    in_vsync = 1'b0; in_href = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    modelReset();
    tick();
    tick();
    checks++;
    if ({out_vsync, out_href, out_valid, out_data, frame_active, frame_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0",
               {out_vsync, out_href, out_valid, out_data, frame_active, frame_cnt});
    end
    checks++;
    if ({line_len_err, line_cnt_err, last_line_len, last_frame_lines} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_geom got=%h exp=0",
               {line_len_err, line_cnt_err, last_line_len, last_frame_lines});
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ep, ok; int e, g;
    obsQ.delete();
    rst = 1'b0;
    in_data = 16'hA5A5;
    for (int l = 0; l < 5; l++) driveLine(H, 1'b0, 1'b0);
    checks++;
    if (obsQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL midframe_blocked got=%0d exp=0", obsQ.size());
    end
    driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
    checks++;
    if (g != H * V || !ok) begin
      failures++;
      $display("[TB] FAIL first_full_frame got=%0d exp=%0d dataOk=%0d", g, H * V, ok);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL first_frame_cnt got=%0d exp=1", frame_cnt);
    end
    checks++;
    if (line_len_err !== 1'b0 || line_cnt_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_frame_errs got=%b%b exp=00", line_len_err, line_cnt_err);
    end
  endtask

  task automatic test_decimation();
    bit ep, ok; int e, g;
    int fcBefore = int'(frame_cnt);
    int ovBefore = ovRise;
    bit pattern[7];
    keep_div = 4'd2;
    capture_en = 1'b1;
    for (int f = 0; f < 7; f++) begin
      driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
      pattern[f] = (g != 0);
      checks++;
      if (g != e || !ok) begin
        failures++;
        $display("[TB] FAIL decim_frame%0d got=%0d exp=%0d", f + 1, g, e);
      end
    end
    checks++;
    if (!(pattern[0] && !pattern[1] && !pattern[2] && pattern[3] &&
          !pattern[4] && !pattern[5] && pattern[6])) begin
      failures++;
      $display("[TB] FAIL decim_pattern got=%b%b%b%b%b%b%b exp=1001001", pattern[0], pattern[1],
               pattern[2], pattern[3], pattern[4], pattern[5], pattern[6]);
    end
    checks++;
    if (int'(frame_cnt) - fcBefore != 3) begin
      failures++;
      $display("[TB] FAIL decim_frame_cnt got=%0d exp=3", int'(frame_cnt) - fcBefore);
    end
    checks++;
    if (ovRise - ovBefore != 7) begin
      failures++;
      $display("[TB] FAIL decim_vsync got=%0d exp=7", ovRise - ovBefore);
    end
  endtask

  task automatic test_capture_drop();
    bit ep, ok; int e, g;
    keep_div = 4'd0;
    capture_en = 1'b1;
    while (!modelWillPass(1'b1, 0)) begin
      driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
      checks++;
      if (g != e || !ok) begin
        failures++;
        $display("[TB] FAIL drop_prelude got=%0d exp=%0d", g, e);
      end
    end
    driveFrame(V, -1, 0, -1, V / 2, ep, e, g, ok);
    checks++;
    if (g != H * V || !ok) begin
      failures++;
      $display("[TB] FAIL drop_frame_completes got=%0d exp=%0d", g, H * V);
    end
    driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
    checks++;
    if (g != 0) begin
      failures++;
      $display("[TB] FAIL drop_next_blocked got=%0d exp=0", g);
    end
    checks++;
    if (frame_active !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drop_idle got=%b exp=0", frame_active);
    end
    capture_en = 1'b1;
  endtask

  task automatic test_line_len();
    bit ep, ok; int e, g;
    keep_div = 4'd0;
    capture_en = 1'b1;
    while (!modelWillPass(1'b1, 0)) driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
    pulseClear();
    checks++;
    if (line_len_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL len_err_initial got=%b exp=0", line_len_err);
    end
    driveFrame(V, V - 1, H - 1, -1, -1, ep, e, g, ok);
    checks++;
    if (line_len_err !== 1'b1 || last_line_len !== CW'(H - 1)) begin
      failures++;
      $display("[TB] FAIL len_err_short got=%b/%0d exp=1/%0d", line_len_err, last_line_len, H - 1);
    end
    pulseClear();
    checks++;
    if (line_len_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL len_err_clear got=%b exp=0", line_len_err);
    end
    driveFrame(V, V - 1, H + 1, V - 1, -1, ep, e, g, ok);
    checks++;
    if (line_len_err !== 1'b1 || last_line_len !== CW'(H + 1)) begin
      failures++;
      $display("[TB] FAIL len_err_set_wins got=%b/%0d exp=1/%0d", line_len_err, last_line_len, H + 1);
    end
    pulseClear();
  endtask

  task automatic test_line_cnt();
    bit ep, ok; int e, g;
    keep_div = 4'd0;
    capture_en = 1'b1;
    while (!modelWillPass(1'b1, 0)) driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
    pulseClear();
    driveFrame(V - 1, -1, 0, -1, -1, ep, e, g, ok);
    checks++;
    if (line_cnt_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cnt_err_early got=%b exp=0", line_cnt_err);
    end
    keep_div = 4'd1;
    driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
    checks++;
    if (line_cnt_err !== 1'b1 || last_frame_lines !== CW'(V - 1)) begin
      failures++;
      $display("[TB] FAIL cnt_err_short got=%b/%0d exp=1/%0d", line_cnt_err, last_frame_lines, V - 1);
    end
    pulseClear();
    driveFrame(V - 1, 0, H - 2, -1, -1, ep, e, g, ok);
    checks++;
    if (ep || g != 0) begin
      failures++;
      $display("[TB] FAIL skipped_frame_blocked got=%0d exp=0", g);
    end
    driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
    checks++;
    if (line_cnt_err !== 1'b0 || line_len_err !== 1'b0 || last_frame_lines !== CW'(V - 1)) begin
      failures++;
      $display("[TB] FAIL skipped_no_err got=%b%b/%0d exp=00/%0d",
               line_cnt_err, line_len_err, last_frame_lines, V - 1);
    end
  endtask

  task automatic test_random();
    bit ep, ok; int e, g;
    capture_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      keep_div = 4'($urandom_range(0, 3));
      for (int f = 0; f < 4; f++) begin
        driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
        checks++;
        if (g != e || !ok) begin
          failures++;
          $display("[TB] FAIL random_frame r%0d f%0d got=%0d exp=%0d", r, f, g, e);
        end
      end
    end
    checks++;
    if (int'(frame_cnt) != mFrameCnt) begin
      failures++;
      $display("[TB] FAIL random_frame_cnt got=%0d exp=%0d", frame_cnt, mFrameCnt);
    end
    checks++;
    if (dataLeak != 0) begin
      failures++;
      $display("[TB] FAIL data_leak got=%0d exp=0", dataLeak);
    end
  endtask

  task automatic test_async_reset();
    bit ep, ok, seen; int e, g;
    keep_div = 4'd0;
    capture_en = 1'b1;
    while (!modelWillPass(1'b1, 0)) driveFrame(V, -1, 0, -1, -1, ep, e, g, ok);
    modelStep(1'b1, 0);
    in_vsync = 1'b1;
    tick();
    in_vsync = 1'b0;
    tick();
    in_href = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h1234;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = (out_valid === 1'b1);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL async_wait_valid got=0 exp=1");
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_vsync, out_href, out_valid, out_data, frame_active, frame_cnt, line_len_err,
         line_cnt_err, last_line_len, last_frame_lines} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b%b%b/%h/%b/%0d exp=all zero",
               out_vsync, out_href, out_valid, out_data, frame_active, frame_cnt);
    end
    in_href = 1'b0;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    modelReset();
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_decimation();
    test_capture_drop();
    test_line_len();
    test_line_cnt();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
